// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM encoding,
// master index type and the default timeout length.
package mem_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int ID_W = 1;
    typedef logic [ID_W-1:0] id_t;

    localparam int TIMEOUT_CYCLES_DEFAULT = 256;

    // Index of the master that is not 'id'.
    function automatic id_t other_id(input id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/mem_arbiter_timer.sv
// Slave-wait counter for the arbiter. Counts consecutive BUSY cycles
// without slave completion and flags the cycle in which the count reaches
// LIMIT. Only instantiated when MEM_ARBITER_TIMEOUT_EN is defined.
module mem_arbiter_timer
    import mem_arbiter_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic busy,
    input  logic done,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    // Count BUSY cycles; restart whenever the arbiter is idle or the slave completes.
    always_ff @(posedge clk) begin
        if (reset || !busy || done) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    // The first BUSY cycle sees count 0, so LIMIT-1 marks the LIMIT-th cycle.
    assign expired = busy && !done && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-master, one-slave round-robin memory arbiter.
// Optional feature: define MEM_ARBITER_TIMEOUT_EN to force completion of a
// transaction after TIMEOUT_CYCLES slave-wait cycles and raise a sticky
// timeout_err. Without it the arbiter waits indefinitely for s_ready.
//
// Handshake: a master holds mN_valid with stable addr/wdata/wstrb until it
// sees mN_ready high for one cycle (completion, rdata valid in that cycle).
// Dropping valid before completion aborts the request. The slave sees
// s_valid with stable request fields until it answers s_ready for one cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    output logic        grant_id,
    output logic        timeout_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    state_t state;
    id_t    owner;
    id_t    rr_ptr;

    logic active;
    logic owner_is_1;
    logic owner_valid;
    logic timeout_hit;
    logic complete;

    // Reset gates the outputs immediately so a transaction caught by reset
    // never shows a ready or a slave request.
    assign active      = (state == ST_BUSY) && !reset;
    assign owner_is_1  = (owner == 1'b1);
    assign owner_valid = owner_is_1 ? m1_valid : m0_valid;
    assign complete    = s_ready || timeout_hit;

`ifdef MEM_ARBITER_TIMEOUT_EN
    logic expired;
    logic err_q;

    mem_arbiter_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .busy    (state == ST_BUSY),
        .done    (s_ready),
        .expired (expired)
    );

    // An abort in the terminal cycle wins over the forced completion.
    assign timeout_hit = expired && owner_valid;

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign timeout_err = err_q && !reset;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Arbitration FSM: grant in IDLE, hold ownership in BUSY until
    // completion or abort. The pointer only moves on a real completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            owner  <= 1'b0;
            rr_ptr <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m0_valid && m1_valid) begin
                        owner <= rr_ptr;
                        state <= ST_BUSY;
                    end else if (m0_valid) begin
                        owner <= 1'b0;
                        state <= ST_BUSY;
                    end else if (m1_valid) begin
                        owner <= 1'b1;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (complete) begin
                        state  <= ST_IDLE;
                        rr_ptr <= other_id(owner);
                    end else if (!owner_valid) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Slave request mirrors the owner's request fields while BUSY.
    assign s_valid = active;
    assign s_addr  = !active ? 32'h0 : (owner_is_1 ? m1_addr  : m0_addr);
    assign s_wdata = !active ? 32'h0 : (owner_is_1 ? m1_wdata : m0_wdata);
    assign s_wstrb = !active ? 4'h0  : (owner_is_1 ? m1_wstrb : m0_wstrb);

    // Completion and read data go to the owner only; a forced completion
    // returns zero data.
    assign m0_ready = active && !owner_is_1 && complete;
    assign m1_ready = active &&  owner_is_1 && complete;
    assign m0_rdata = (active && !owner_is_1 && !timeout_hit) ? s_rdata : 32'h0;
    assign m1_rdata = (active &&  owner_is_1 && !timeout_hit) ? s_rdata : 32'h0;

    assign grant_id = reset ? 1'b0 : owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Stimulus pushes expected grants
// ({id, addr, wdata, wstrb}) and completions ({m1_ready, m0_ready,
// m0_rdata, m1_rdata}) into queues; a monitor pops and compares them
// whenever the DUT starts a slave request or raises a master ready.
// Define MEM_ARBITER_TIMEOUT_EN for the timeout build.
module tb_mem_arbiter;

    localparam int TO_CYCLES = 8;
    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        grant_id, timeout_err;

    mem_arbiter #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .clk (clk), .reset (reset),
        .m0_valid (m0_valid), .m0_ready (m0_ready), .m0_addr (m0_addr),
        .m0_wdata (m0_wdata), .m0_wstrb (m0_wstrb), .m0_rdata (m0_rdata),
        .m1_valid (m1_valid), .m1_ready (m1_ready), .m1_addr (m1_addr),
        .m1_wdata (m1_wdata), .m1_wstrb (m1_wstrb), .m1_rdata (m1_rdata),
        .s_valid (s_valid), .s_ready (s_ready), .s_addr (s_addr),
        .s_wdata (s_wdata), .s_wstrb (s_wstrb), .s_rdata (s_rdata),
        .grant_id (grant_id), .timeout_err (timeout_err)
    );

    // ---------------- scoreboard state ----------------
    logic [68:0] exp_grant_q[$];
    logic [65:0] exp_done_q[$];
    logic [31:0] slave_q[$];
    logic [67:0] req0_q[$];
    logic [67:0] req1_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt0 = 0, done_cnt1 = 0;
    int n_grants = 0, n_dones = 0, neg_cnt = 0;
    int grant_at[64];
    int done_at[64];

    bit slave_en  = 1'b1;
    int slave_lat = 2;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event occurred or bound expired", name);
    endtask

    // ---------------- driver tasks ----------------
    task automatic expect_grant(input logic id, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb);
        exp_grant_q.push_back({id, addr, wdata, wstrb});
    endtask

    task automatic expect_done(input logic id, input logic [31:0] rdata, input bit from_slave);
        exp_done_q.push_back(id ? {2'b10, 32'h0, rdata} : {2'b01, rdata, 32'h0});
        if (from_slave) slave_q.push_back(rdata);
    endtask

    task automatic expect_txn(input logic id, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input logic [31:0] rdata);
        expect_grant(id, addr, wdata, wstrb);
        expect_done(id, rdata, 1'b1);
        if (id) req1_q.push_back({addr, wdata, wstrb});
        else    req0_q.push_back({addr, wdata, wstrb});
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Drive queued requests; each master drops or replaces its request the
    // cycle after its ready is observed.
    task automatic run_traffic(input int budget);
        int s0 = done_cnt0;
        int s1 = done_cnt1;
        int cyc = 0;
        forever begin
            @(posedge clk); #1;
            if (done_cnt0 != s0) begin s0 = done_cnt0; m0_valid = 1'b0; end
            if (done_cnt1 != s1) begin s1 = done_cnt1; m1_valid = 1'b0; end
            if (!m0_valid && req0_q.size() > 0) begin
                {m0_addr, m0_wdata, m0_wstrb} = req0_q.pop_front();
                m0_valid = 1'b1;
            end
            if (!m1_valid && req1_q.size() > 0) begin
                {m1_addr, m1_wdata, m1_wstrb} = req1_q.pop_front();
                m1_valid = 1'b1;
            end
            if (!m0_valid && !m1_valid && exp_done_q.size() == 0 && exp_grant_q.size() == 0)
                break;
            cyc++;
            if (cyc > budget) begin
                fail_now("traffic_budget");
                m0_valid = 1'b0; m1_valid = 1'b0;
                req0_q.delete(); req1_q.delete();
                exp_grant_q.delete(); exp_done_q.delete(); slave_q.delete();
                break;
            end
        end
    endtask

    // ---------------- slave model ----------------
    initial begin
        int cnt = 0;
        s_ready = 1'b0;
        s_rdata = JUNK;
        forever begin
            @(posedge clk); #1;
            if (reset || s_ready) begin
                s_ready = 1'b0;
                s_rdata = JUNK;
                cnt = 0;
            end else if (s_valid && slave_en) begin
                cnt++;
                if (cnt >= slave_lat) begin
                    s_ready = 1'b1;
                    s_rdata = (slave_q.size() > 0) ? slave_q.pop_front() : 32'h0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic prev_sv = 1'b0;
        logic [68:0] eg;
        logic [65:0] ed;
        forever begin
            @(negedge clk);
            neg_cnt++;
            if (!reset) begin
                if (s_valid && !prev_sv) begin
                    grant_at[n_grants % 64] = neg_cnt;
                    n_grants++;
                    if (exp_grant_q.size() == 0) fail_now("unexpected_grant");
                    else begin
                        eg = exp_grant_q.pop_front();
                        check("grant", {grant_id, s_addr, s_wdata, s_wstrb}, eg);
                    end
                end
                if (m0_ready || m1_ready) begin
                    done_at[n_dones % 64] = neg_cnt;
                    n_dones++;
                    if (m0_ready) done_cnt0++;
                    if (m1_ready) done_cnt1++;
                    if (exp_done_q.size() == 0) fail_now("unexpected_ready");
                    else begin
                        ed = exp_done_q.pop_front();
                        check("done", {m1_ready, m0_ready, m0_rdata, m1_rdata}, ed);
                    end
                end
            end
            prev_sv = s_valid;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int g0, d0, busy_cycles;

        // Reset state
        @(negedge clk); @(negedge clk);
        check("rst_s_valid", s_valid, 1'b0);
        check("rst_ready", {m0_ready, m1_ready}, 2'b00);
        check("rst_grant_id", grant_id, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_rdata", {m0_rdata, m1_rdata}, 64'h0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_s_addr", {s_valid, s_addr, s_wdata, s_wstrb}, 69'h0);

        // m0 read of 0x100, slave answers DEADBEEF after 2 cycles
        slave_lat = 2;
        expect_grant(1'b0, 32'h100, 32'h0, 4'h0);
        expect_done(1'b0, 32'hDEADBEEF, 1'b1);
        @(posedge clk); #1;
        m0_addr = 32'h100; m0_wdata = 32'h0; m0_wstrb = 4'h0; m0_valid = 1'b1;
        @(negedge clk);
        check("lat_before", s_valid, 1'b0);
        @(negedge clk);
        check("lat_one", s_valid, 1'b1);
        run_traffic(100);

        // Simultaneous requests after reset: m0 first, then m1 after one idle cycle
        apply_reset();
        g0 = n_grants; d0 = n_dones;
        expect_txn(1'b0, 32'h400, 32'h0, 4'h0, 32'h1111_0000);
        expect_txn(1'b1, 32'h500, 32'h0, 4'h0, 32'h2222_0000);
        run_traffic(100);
        check("b2b_gap", grant_at[(g0 + 1) % 64] - done_at[d0 % 64], 2);

        // Both masters continuously requesting: grants alternate 0,1,0,1,0,1
        slave_lat = 1;
        g0 = n_grants; d0 = n_dones;
        expect_txn(1'b0, 32'h1000, 32'h0, 4'h0, 32'hA000_0001);
        expect_txn(1'b1, 32'h3000, 32'h0, 4'h0, 32'hB000_0001);
        expect_txn(1'b0, 32'h1004, 32'h0, 4'h0, 32'hA000_0002);
        expect_txn(1'b1, 32'h3004, 32'h0, 4'h0, 32'hB000_0002);
        expect_txn(1'b0, 32'h1008, 32'h0, 4'h0, 32'hA000_0003);
        expect_txn(1'b1, 32'h3008, 32'h0, 4'h0, 32'hB000_0003);
        run_traffic(200);
        for (int i = 0; i < 5; i++)
            check("alt_gap", grant_at[(g0 + i + 1) % 64] - done_at[(d0 + i) % 64], 2);

        // m1 write: request fields forwarded to the slave
        slave_lat = 3;
        expect_txn(1'b1, 32'h2000, 32'h1234_5678, 4'b0011, 32'h0);
        run_traffic(100);
        @(negedge clk);
        check("idle_hold_grant", {s_valid, grant_id}, 2'b01);
        @(negedge clk);
        check("idle_hold_grant2", {s_valid, grant_id}, 2'b01);

        // Abort: m0 drops valid mid-BUSY, no ready, pointer unchanged (still m0)
        slave_en = 1'b0;
        expect_grant(1'b0, 32'h900, 32'h0, 4'h0);
        @(posedge clk); #1;
        m0_addr = 32'h900; m0_wdata = 32'h0; m0_wstrb = 4'h0; m0_valid = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk); #1 m0_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        check("abort_idle", {s_valid, m0_ready, m1_ready}, 3'b000);
        slave_en = 1'b1;
        slave_lat = 2;
        expect_txn(1'b0, 32'h940, 32'h0, 4'h0, 32'h0A0A_0001);
        expect_txn(1'b1, 32'h980, 32'h0, 4'h0, 32'h0B0B_0001);
        run_traffic(100);

        // Slave never answers
        slave_en = 1'b0;
        expect_grant(1'b0, 32'h600, 32'h0, 4'h0);
        @(posedge clk); #1;
        m0_addr = 32'h600; m0_wdata = 32'h0; m0_wstrb = 4'h0; m0_valid = 1'b1;
`ifdef MEM_ARBITER_TIMEOUT_EN
        expect_done(1'b0, 32'h0, 1'b0);
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (s_valid) busy_cycles++;
            if (m0_ready) break;
        end
        check("timeout_cycles", busy_cycles, TO_CYCLES);
        @(posedge clk); #1 m0_valid = 1'b0;
        @(negedge clk);
        check("timeout_err_set", {s_valid, timeout_err}, 2'b01);
        repeat (3) @(negedge clk);
        check("timeout_err_sticky", timeout_err, 1'b1);
        slave_en = 1'b1;
`else
        repeat (20) @(negedge clk);
        check("no_timeout_wait", {s_valid, m0_ready, timeout_err}, 3'b100);
        expect_done(1'b0, 32'h600D_600D, 1'b1);
        slave_en = 1'b1;
        run_traffic(100);
`endif
        expect_txn(1'b0, 32'h640, 32'h0, 4'h0, 32'h0C0C_0001);
        run_traffic(100);
        @(negedge clk);
`ifdef MEM_ARBITER_TIMEOUT_EN
        check("timeout_err_after_txn", timeout_err, 1'b1);
`else
        check("timeout_err_after_txn", timeout_err, 1'b0);
`endif

        // Reset mid-BUSY with m1 owning; pointer was favouring m1 before reset
        slave_en = 1'b0;
        expect_grant(1'b1, 32'h880, 32'h0, 4'h0);
        @(posedge clk); #1;
        m1_addr = 32'h880; m1_wdata = 32'h0; m1_wstrb = 4'h0; m1_valid = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        m1_valid = 1'b0;
        @(negedge clk);
        check("rst_busy_during", {s_valid, m0_ready, m1_ready, grant_id, timeout_err}, 5'b0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy_after", {s_valid, m0_ready, m1_ready, grant_id, timeout_err}, 5'b0);
        slave_en = 1'b1;
        expect_txn(1'b0, 32'h700, 32'h0, 4'h0, 32'h7777_0000);
        expect_txn(1'b1, 32'h800, 32'h0, 4'h0, 32'h8888_0000);
        run_traffic(100);

        repeat (3) @(negedge clk);
        check("final_queues_empty", exp_grant_q.size() + exp_done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning slave-wait cycles before a forced completion (timeout build only).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports m0_valid/m1_valid, input, 1, master request.
REQ-005 SHALL have ports m0_ready/m1_ready, output, 1, master completion strobe.
REQ-006 SHALL have ports m0_addr/m1_addr, input, 32, master byte address.
REQ-007 SHALL have ports m0_wdata/m1_wdata, input, 32, master write data.
REQ-008 SHALL have ports m0_wstrb/m1_wstrb, input, 4, byte write strobes; 0 means read.
REQ-009 SHALL have ports m0_rdata/m1_rdata, output, 32, master read data.
REQ-010 SHALL have port s_valid, output, 1, slave request.
REQ-011 SHALL have port s_ready, input, 1, slave completion.
REQ-012 SHALL have ports s_addr (output, 32), s_wdata (output, 32), s_wstrb (output, 4) and s_rdata (input, 32) as the slave bus.
REQ-013 SHALL have port grant_id, output, 1, index of the current owner.
REQ-014 SHALL have port timeout_err, output, 1, sticky timeout flag.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-016 In IDLE with exactly one valid asserted, SHALL register that master as owner and enter BUSY next cycle.
REQ-017 In IDLE with both valids asserted, SHALL grant the master indicated by the round-robin pointer.
REQ-018 The round-robin pointer SHALL favour the master not most recently completed.
REQ-019 In BUSY, s_valid SHALL be 1, and s_addr/s_wdata/s_wstrb SHALL combinationally follow the owner's inputs.
REQ-020 In IDLE, s_valid SHALL be 0 and s_addr/s_wdata/s_wstrb SHALL be 0.
REQ-021 m<owner>_ready SHALL equal s_ready while BUSY, and m<owner>_rdata SHALL equal s_rdata while BUSY.
REQ-022 The non-owner's ready SHALL be 0 and its rdata SHALL be 0.
REQ-023 On s_ready in BUSY, SHALL return to IDLE next cycle and point the round-robin pointer at the other master.
REQ-024 Request-to-s_valid latency SHALL be exactly 1 cycle.
REQ-025 Back-to-back grants SHALL be separated by exactly one IDLE cycle.
REQ-026 If the owner drops valid in BUSY before s_ready (abort), SHALL return to IDLE, give no ready, and leave the pointer unchanged.
REQ-027 A master waiting in IDLE arbitration SHALL see ready 0 until it is granted and the slave completes.
REQ-028 grant_id SHALL hold the last owner in IDLE.

Reset
REQ-029 While reset is high, SHALL force IDLE, grant_id 0, pointer favouring m0, s_valid 0, both readys 0, timeout_err 0, and timeout counter 0.
REQ-030 Reset asserted in BUSY SHALL abandon the transaction with no ready issued on the cycle following reset.

Configuration
REQ-031 With macro MEM_ARBITER_TIMEOUT_EN defined, SHALL count BUSY cycles without s_ready.
REQ-032 With the macro defined, on reaching TIMEOUT_CYCLES it SHALL pulse owner ready for one cycle with rdata 0, set timeout_err, and return to IDLE.
REQ-033 With the macro defined, timeout_err SHALL clear only on reset.
REQ-034 Without the macro, SHALL contain no counter, tie timeout_err to 0, and wait indefinitely for s_ready.

Structure
REQ-035 Package mem_arbiter_pkg SHALL hold the FSM state encoding, master-index width (1), and the TIMEOUT_CYCLES default.
REQ-036 One sub-module, mem_arbiter_timer (counter plus terminal-count compare), SHALL be instantiated only under MEM_ARBITER_TIMEOUT_EN.

Verification
REQ-037 Bench SHALL check: m0 read of 0x100, slave returns 0xDEADBEEF after 2 cycles -> s_valid high 1 cycle after m0_valid, m0_rdata 0xDEADBEEF with m0_ready, m1_ready 0.
REQ-038 Bench SHALL check: m0 and m1 valid on the same cycle after reset -> m0 served first, then m1 after one IDLE cycle, grant_id 0 then 1.
REQ-039 Bench SHALL check: both masters continuously requesting for 6 transactions -> grants alternate 0,1,0,1,0,1.
REQ-040 Bench SHALL check: m1 write 0x12345678 wstrb 4'b0011 to 0x2000 -> s_wdata 0x12345678, s_wstrb 4'b0011, s_addr 0x2000 during BUSY.
REQ-041 Bench SHALL check: with TIMEOUT_EN, TIMEOUT_CYCLES=8, s_ready held 0 -> owner ready pulses 8 cycles into BUSY, rdata 0, timeout_err 1 until reset.
REQ-042 Bench SHALL check: reset asserted mid-BUSY -> next cycle IDLE, s_valid 0, no ready pulse, pointer favours m0.
